// File: rtl/riscv_pkg.sv
// Shared RV64 decode definitions: opcodes, ALU operation classes, control and ID/EX bundles.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst_addr;
        logic [XLEN-1:0] read_data1;
        logic [XLEN-1:0] read_data2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      funct4;
        ctrl_t           ctrl;
    } idex_t;

    // Only these formats carry a real rs2 field; others would raise false load-use hazards.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x64 integer register file, two async read ports with write-through bypass, x0 hardwired to 0.
// Latency: reads combinational; writes visible to same-cycle reads via bypass, stored on the rising edge.
// Backpressure: none; writes are always accepted.
module register_file
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    input  logic            write_en,
    input  logic [4:0]      write_addr,
    input  logic [XLEN-1:0] write_data
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_ok;

    assign wr_ok = write_en && (write_addr != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[write_addr] <= write_data;
        end
    end

    // Bypass lets write-back and decode share a cycle without a forwarding hole.
    always_comb begin
        read_data1 = regs[rs1];
        if (rs1 == 5'd0) begin
            read_data1 = '0;
        end else if (wr_ok && (write_addr == rs1)) begin
            read_data1 = write_data;
        end

        read_data2 = regs[rs2];
        if (rs2 == 5'd0) begin
            read_data2 = '0;
        end else if (wr_ok && (write_addr == rs2)) begin
            read_data2 = write_data;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV64 instruction decode: register read, control/immediate generation, load-use detection, ID/EX register.
// Latency: 1 cycle from instruction_in to ex_*; hazard_stall is combinational.
// Backpressure: stall holds ID/EX; hazard_stall asks upstream to hold while a bubble is inserted.
module decode_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instruction_in,
    input  logic [XLEN-1:0] inst_addr_in,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            hazard_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_inst_addr,
    output logic [XLEN-1:0] ex_read_data1,
    output logic [XLEN-1:0] ex_read_data2,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_funct4,
    output logic            ex_branch,
    output logic            ex_mem_read,
    output logic            ex_mem_to_reg,
    output logic            ex_mem_write,
    output logic            ex_alu_src,
    output logic            ex_reg_write,
    output logic [1:0]      ex_alu_op
);

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rf_data1;
    logic [XLEN-1:0] rf_data2;
    ctrl_t           ctrl;
    logic [XLEN-1:0] imm;
    idex_t           idex_d;
    idex_t           idex_q;

    assign opcode = instruction_in[6:0];
    assign rd     = instruction_in[11:7];
    assign rs1    = instruction_in[19:15];
    assign rs2    = instruction_in[24:20];

    register_file u_register_file (
        .clk        (clk),
        .reset      (reset),
        .rs1        (rs1),
        .rs2        (rs2),
        .read_data1 (rf_data1),
        .read_data2 (rf_data2),
        .write_en   (wb_reg_write),
        .write_addr (wb_rd),
        .write_data (wb_data)
    );

    // Branch immediate stays in half-word units; EX applies the shift.
    always_comb begin
        ctrl = '0;
        imm  = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_R;
            end
            OP_IALU: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_I;
                imm = {{(XLEN-12){instruction_in[31]}}, instruction_in[31:20]};
            end
            OP_LOAD: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALUOP_MEM;
                imm = {{(XLEN-12){instruction_in[31]}}, instruction_in[31:20]};
            end
            OP_STORE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_MEM;
                imm = {{(XLEN-12){instruction_in[31]}}, instruction_in[31:25], instruction_in[11:7]};
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_BR;
                imm = {{(XLEN-12){instruction_in[31]}}, instruction_in[31], instruction_in[7],
                       instruction_in[30:25], instruction_in[11:8]};
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        idex_d            = '0;
        idex_d.valid      = 1'b1;
        idex_d.inst_addr  = inst_addr_in;
        idex_d.read_data1 = rf_data1;
        idex_d.read_data2 = rf_data2;
        idex_d.imm        = imm;
        idex_d.rs1        = rs1;
        idex_d.rs2        = rs2;
        idex_d.rd         = rd;
        idex_d.funct4     = {instruction_in[30], instruction_in[14:12]};
        idex_d.ctrl       = ctrl;
    end

    assign hazard_stall = idex_q.valid && idex_q.ctrl.mem_read && (idex_q.rd != 5'd0) &&
                          ((idex_q.rd == rs1) || ((idex_q.rd == rs2) && uses_rs2(opcode)));

    // Flush beats stall so a taken branch can never leave a held wrong-path op in EX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q <= '0;
        end else if (flush) begin
            idex_q <= '0;
        end else if (!stall) begin
            if (hazard_stall) begin
                idex_q <= '0;
            end else begin
                idex_q <= idex_d;
            end
        end
    end

    assign ex_valid      = idex_q.valid;
    assign ex_inst_addr  = idex_q.inst_addr;
    assign ex_read_data1 = idex_q.read_data1;
    assign ex_read_data2 = idex_q.read_data2;
    assign ex_imm        = idex_q.imm;
    assign ex_rs1        = idex_q.rs1;
    assign ex_rs2        = idex_q.rs2;
    assign ex_rd         = idex_q.rd;
    assign ex_funct4     = idex_q.funct4;
    assign ex_branch     = idex_q.ctrl.branch;
    assign ex_mem_read   = idex_q.ctrl.mem_read;
    assign ex_mem_to_reg = idex_q.ctrl.mem_to_reg;
    assign ex_mem_write  = idex_q.ctrl.mem_write;
    assign ex_alu_src    = idex_q.ctrl.alu_src;
    assign ex_reg_write  = idex_q.ctrl.reg_write;
    assign ex_alu_op     = idex_q.ctrl.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode table, hand-written pipeline corner cases, then random traffic
// compared against a reference model built from the instruction-set rules.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_in;
    logic [63:0] inst_addr_in;
    logic        stall;
    logic        flush;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        hazard_stall;
    logic        ex_valid;
    logic [63:0] ex_inst_addr;
    logic [63:0] ex_read_data1;
    logic [63:0] ex_read_data2;
    logic [63:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_funct4;
    logic        ex_branch;
    logic        ex_mem_read;
    logic        ex_mem_to_reg;
    logic        ex_mem_write;
    logic        ex_alu_src;
    logic        ex_reg_write;
    logic [1:0]  ex_alu_op;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk            (clk),
        .reset          (reset),
        .instruction_in (instruction_in),
        .inst_addr_in   (inst_addr_in),
        .stall          (stall),
        .flush          (flush),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .hazard_stall   (hazard_stall),
        .ex_valid       (ex_valid),
        .ex_inst_addr   (ex_inst_addr),
        .ex_read_data1  (ex_read_data1),
        .ex_read_data2  (ex_read_data2),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_rd          (ex_rd),
        .ex_funct4      (ex_funct4),
        .ex_branch      (ex_branch),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_to_reg  (ex_mem_to_reg),
        .ex_mem_write   (ex_mem_write),
        .ex_alu_src     (ex_alu_src),
        .ex_reg_write   (ex_reg_write),
        .ex_alu_op      (ex_alu_op)
    );

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  funct4;
        logic        branch;
        logic        mem_read;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_write;
        logic [1:0]  alu_op;
    } ex_t;

    // ctrl column order: alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch
    typedef struct packed {
        logic [31:0] ins;
        logic [5:0]  ctrl;
        logic [1:0]  alu_op;
        logic [63:0] imm;
        logic [3:0]  funct4;
    } vec_t;

    localparam logic [31:0] ADD_X7_X5_X6  = 32'h006283B3;
    localparam logic [31:0] ADD_X7_X0_X0  = 32'h000003B3;
    localparam logic [31:0] LD_X4_M8_X3   = 32'hFF81B203;
    localparam logic [31:0] LD_X4_0_X3    = 32'h0001B203;
    localparam logic [31:0] ADD_X5_X4_X1  = 32'h001202B3;
    localparam logic [31:0] BEQ_X1_X2_M16 = 32'hFE2088E3;
    localparam logic [31:0] NOP           = 32'h00000013;

    ex_t         act;
    ex_t         mst;
    logic [63:0] mregs [32];
    int          vectors = 0;
    int          miscompares = 0;

    assign act = {ex_valid, ex_inst_addr, ex_read_data1, ex_read_data2, ex_imm, ex_rs1, ex_rs2,
                  ex_rd, ex_funct4, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
                  ex_alu_src, ex_reg_write, ex_alu_op};

    task automatic chk64(input string name, input logic [63:0] a, input logic [63:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    task automatic chk_ex(input string name, input ex_t a, input ex_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (wb_reg_write && wb_rd == a) return wb_data;
        return mregs[a];
    endfunction

    function automatic bit m_reads_rs2(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
    endfunction

    function automatic bit m_hazard();
        logic [4:0] r1 = instruction_in[19:15];
        logic [4:0] r2 = instruction_in[24:20];
        if (!(mst.valid && mst.mem_read) || mst.rd == 5'd0) return 1'b0;
        return (mst.rd == r1) || (mst.rd == r2 && m_reads_rs2(instruction_in[6:0]));
    endfunction

    function automatic ex_t m_decode();
        ex_t                r = '0;
        logic [5:0]         c = 6'b000000;
        logic signed [63:0] sx = 0;
        logic signed [63:0] boff;
        logic [31:0]        i = instruction_in;
        r.valid  = 1'b1;
        r.addr   = inst_addr_in;
        r.rs1    = i[19:15];
        r.rs2    = i[24:20];
        r.rd     = i[11:7];
        r.rd1    = mread(i[19:15]);
        r.rd2    = mread(i[24:20]);
        r.funct4 = {i[30], i[14:12]};
        case (i[6:0])
            7'b0110011: begin c = 6'b001000; r.alu_op = 2'b10; sx = 0; end
            7'b0010011: begin c = 6'b101000; r.alu_op = 2'b11; sx = $signed(i[31:20]); end
            7'b0000011: begin c = 6'b111100; r.alu_op = 2'b00; sx = $signed(i[31:20]); end
            7'b0100011: begin c = 6'b100010; r.alu_op = 2'b00; sx = $signed({i[31:25], i[11:7]}); end
            7'b1100011: begin
                c = 6'b000001;
                r.alu_op = 2'b01;
                boff = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
                sx = boff / 2;
            end
            default: begin c = 6'b000000; r.alu_op = 2'b00; sx = 0; end
        endcase
        r.imm        = sx;
        r.alu_src    = c[5];
        r.mem_to_reg = c[4];
        r.reg_write  = c[3];
        r.mem_read   = c[2];
        r.mem_write  = c[1];
        r.branch     = c[0];
        return r;
    endfunction

    task automatic model_edge();
        bit  hz = m_hazard();
        ex_t nx = m_decode();
        if (flush)      mst = '0;
        else if (stall) mst = mst;
        else if (hz)    mst = '0;
        else            mst = nx;
        if (wb_reg_write && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
    endtask

    task automatic model_reset();
        mst = '0;
        for (int k = 0; k < 32; k++) mregs[k] = 64'd0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drv(input logic [31:0] ins, input logic [63:0] pc, input logic st,
                       input logic fl, input logic we, input logic [4:0] wr, input logic [63:0] wd);
        instruction_in = ins;
        inst_addr_in   = pc;
        stall          = st;
        flush          = fl;
        wb_reg_write   = we;
        wb_rd          = wr;
        wb_data        = wd;
    endtask

    task automatic step(input string name);
        #1;
        chk64({name, "_hazard"}, {63'd0, hazard_stall}, {63'd0, m_hazard()});
        @(posedge clk);
        model_edge();
        #1;
        chk_ex(name, act, mst);
    endtask

    vec_t tbl [7];

    initial begin
        tbl[0] = '{ADD_X7_X5_X6,  6'b001000, 2'b10, 64'h0,                  4'h0};
        tbl[1] = '{32'hFFF08413,  6'b101000, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 4'h8};
        tbl[2] = '{LD_X4_M8_X3,   6'b111100, 2'b00, 64'hFFFF_FFFF_FFFF_FFF8, 4'hB};
        tbl[3] = '{32'h00613823,  6'b100010, 2'b00, 64'h10,                 4'h3};
        tbl[4] = '{BEQ_X1_X2_M16, 6'b000001, 2'b01, 64'hFFFF_FFFF_FFFF_FFF8, 4'h8};
        tbl[5] = '{32'h123454B7,  6'b000000, 2'b00, 64'h0,                  4'h5};
        tbl[6] = '{32'h40208533,  6'b001000, 2'b10, 64'h0,                  4'h8};

        reset = 1'b1;
        drv(NOP, 64'd0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk_ex("reset_state", act, '0);
        chk64("reset_hazard", {63'd0, hazard_stall}, 64'd0);
        reset = 1'b0;

        // Decode table
        for (int i = 0; i < 7; i++) begin
            drv(tbl[i].ins, 64'h1000 + 64'(i * 4), 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
            step("tbl_model");
            chk64("tbl_ctrl", {58'd0, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read,
                               ex_mem_write, ex_branch}, {58'd0, tbl[i].ctrl});
            chk64("tbl_alu_op", {62'd0, ex_alu_op}, {62'd0, tbl[i].alu_op});
            chk64("tbl_imm", ex_imm, tbl[i].imm);
            chk64("tbl_funct4", {60'd0, ex_funct4}, {60'd0, tbl[i].funct4});
            chk64("tbl_valid", {63'd0, ex_valid}, 64'd1);
        end

        // Write x5 then read it together with a bypassed x6
        drv(NOP, 64'h2000, 1'b0, 1'b0, 1'b1, 5'd5, 64'h1234);
        step("wr_x5");
        drv(ADD_X7_X5_X6, 64'h2004, 1'b0, 1'b0, 1'b1, 5'd6, 64'h10);
        step("add_x7");
        chk64("add_rd1", ex_read_data1, 64'h1234);
        chk64("add_rd2", ex_read_data2, 64'h10);
        chk64("add_reg_write", {63'd0, ex_reg_write}, 64'd1);
        chk64("add_alu_op", {62'd0, ex_alu_op}, 64'd2);

        // Same-cycle bypass into a load, then x0 write is ignored
        drv(LD_X4_M8_X3, 64'h2008, 1'b0, 1'b0, 1'b1, 5'd3, 64'hDEAD);
        step("ld_bypass");
        chk64("ld_rd1", ex_read_data1, 64'hDEAD);
        chk64("ld_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk64("ld_mem_read", {63'd0, ex_mem_read}, 64'd1);
        drv(ADD_X7_X0_X0, 64'h200C, 1'b0, 1'b0, 1'b1, 5'd0, 64'hFFFF);
        step("x0_write");
        chk64("x0_bypass_rd1", ex_read_data1, 64'd0);
        drv(ADD_X7_X0_X0, 64'h2010, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        step("x0_read");
        chk64("x0_stored_rd2", ex_read_data2, 64'd0);

        // Load-use: one hazard cycle, bubble, then the consumer
        drv(LD_X4_0_X3, 64'h2014, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        step("lu_load");
        drv(ADD_X5_X4_X1, 64'h2018, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        #1;
        chk64("lu_hazard_on", {63'd0, hazard_stall}, 64'd1);
        step("lu_bubble");
        chk64("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
        chk64("lu_hazard_off", {63'd0, hazard_stall}, 64'd0);
        step("lu_add");
        chk64("lu_add_valid", {63'd0, ex_valid}, 64'd1);
        chk64("lu_add_rs1", {59'd0, ex_rs1}, 64'd4);

        // Stall together with hazard: ID/EX holds the load, hazard stays up
        drv(LD_X4_0_X3, 64'h201C, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        step("sh_load");
        drv(ADD_X5_X4_X1, 64'h2020, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
        step("sh_hold");
        chk64("sh_hazard_held", {63'd0, hazard_stall}, 64'd1);
        chk64("sh_mem_read_held", {63'd0, ex_mem_read}, 64'd1);
        drv(ADD_X5_X4_X1, 64'h2020, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        step("sh_bubble");
        chk64("sh_bubble_valid", {63'd0, ex_valid}, 64'd0);

        // Branch immediate then flush
        drv(BEQ_X1_X2_M16, 64'h2024, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        step("beq");
        chk64("beq_branch", {63'd0, ex_branch}, 64'd1);
        chk64("beq_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        drv(ADD_X7_X5_X6, 64'h2028, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0);
        step("flush");
        chk64("flush_valid", {63'd0, ex_valid}, 64'd0);

        // Stall for three cycles, then stall+flush
        drv(ADD_X7_X5_X6, 64'h202C, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        step("st_load");
        for (int i = 0; i < 3; i++) begin
            drv(32'h00A00093 + 32'(i), 64'h3000 + 64'(i), 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
            step("st_hold");
            chk64("st_rd", {59'd0, ex_rd}, 64'd7);
            chk64("st_addr", ex_inst_addr, 64'h202C);
            chk64("st_rd1", ex_read_data1, 64'h1234);
        end
        drv(ADD_X7_X5_X6, 64'h2030, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0);
        step("st_flush");
        chk64("st_flush_valid", {63'd0, ex_valid}, 64'd0);

        // Asynchronous reset mid-run
        drv(ADD_X7_X5_X6, 64'h2034, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        step("pre_reset");
        reset = 1'b1;
        #1;
        chk_ex("async_reset", act, '0);
        chk64("async_reset_hazard", {63'd0, hazard_stall}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drv(ADD_X7_X5_X6, 64'h2038, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        step("post_reset");
        chk64("x5_after_reset", ex_read_data1, 64'd0);

        // Random traffic with small register indices to provoke hazards and bypasses
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            logic [6:0]  ops [6];
            ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
            ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b0110111;
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 5)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            drv(ins, {$urandom, $urandom}, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the 64-bit RISC-V pipelined processor. It consumes the instruction and instruction address held in the IF/ID register. It reads a 32×64 register file, generates control signals and the sign-extended immediate, and registers all of it into the ID/EX pipeline register. It also detects load-use hazards and reports them so fetch and IF/ID can hold.

## Interface
Parameters: none. Widths are fixed at XLEN=64 and 32 registers.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- instruction_in  in  32  instruction from the IF/ID register
- inst_addr_in  in  64  PC of that instruction, from the IF/ID register
- stall  in  1  external stall; ID/EX holds its contents
- flush  in  1  branch-taken flush; ID/EX loads a bubble
- wb_reg_write  in  1  write-back enable
- wb_rd  in  5  write-back destination register
- wb_data  in  64  write-back data
- hazard_stall  out  1  combinational load-use hazard; upstream holds PC and IF/ID
- ex_valid  out  1  ID/EX holds a real instruction
- ex_inst_addr  out  64  registered PC
- ex_read_data1, ex_read_data2  out  64  registered rs1 and rs2 operand values
- ex_imm  out  64  registered sign-extended immediate
- ex_rs1, ex_rs2, ex_rd  out  5  registered register indices
- ex_funct4  out  4  registered {inst[30], inst[14:12]}
- ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  out  1  registered control signals
- ex_alu_op  out  2  registered ALU operation class

## Operation
- **Decode by opcode** (columns: alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch; alu_op):
  - R-type 0110011: 0 0 1 0 0 0; alu_op 10
  - I-ALU 0010011: 1 0 1 0 0 0; alu_op 11
  - Load 0000011: 1 1 1 1 0 0; alu_op 00
  - Store 0100011: 1 0 0 0 1 0; alu_op 00
  - Branch 1100011: 0 0 0 0 0 1; alu_op 01
  - Any other opcode: all control signals 0, ex_valid still 1.
- **Immediate generation:**
  - I-type and load: inst[31:20], sign-extended.
  - Store: {inst[31:25], inst[11:7]}, sign-extended.
  - Branch: {inst[31], inst[7], inst[30:25], inst[11:8]}, sign-extended and **not** shifted; EX applies the <<1.
  - R-type: immediate is 0.
- **Register file:**
  - Two combinational read ports and one write port, written on the rising edge when wb_reg_write=1 and wb_rd≠0.
  - x0 always reads 0.
  - Write-through bypass: if wb_reg_write=1, wb_rd≠0 and wb_rd equals a read index in the same cycle, that read returns wb_data.
  - The register file writes regardless of stall, flush or hazard.
- **Load-use hazard:** hazard_stall = ex_valid & ex_mem_read & (ex_rd≠0) & ((ex_rd==rs1) | (ex_rd==rs2 & the opcode uses rs2)). Opcodes that use rs2 are R-type, store and branch.
- **ID/EX update priority on each rising edge:** reset > flush > stall > hazard_stall > normal load.
  - Flush: loads a bubble.
  - Stall: holds all ID/EX contents.
  - hazard_stall: loads a bubble.
  - Normal load: captures the decoded instruction.
- **Bubble:** every ID/EX output is 0, including ex_valid.

## Timing
- Reset (asynchronous): every ex_* output is 0 and all 32 registers are 0. hazard_stall then evaluates to 0 because ex_valid=0.
- Decode latency is 1 cycle: an instruction present on instruction_in before edge N appears on ex_* after edge N.
- Write-back to read: same cycle through the bypass, so no added latency.
- hazard_stall is combinational from ID/EX contents and instruction_in, with no registered delay. It deasserts in the cycle after the bubble is inserted.
- Stall and hazard asserted together: ID/EX holds (stall wins). hazard_stall remains asserted.
- Flush and stall asserted together: bubble (flush wins).
- Reset asserted mid-operation: outputs clear asynchronously without waiting for an edge. The first valid output appears after the first edge following reset deassertion.

## Structure
- Shared package riscv_pkg:
  - opcode constants: OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH
  - alu_op encodings: ALUOP_MEM=00, ALUOP_BR=01, ALUOP_R=10, ALUOP_I=11
  - XLEN=64
- Sub-module register_file: 32×64 storage, asynchronous reset, x0 hardwired to 0, write-through bypass.
- decode_stage contains the decoder, immediate generator, hazard logic and the ID/EX register.

## Test plan
- **Reset:** assert reset mid-run → all ex_* outputs 0 immediately; x5 reads 0 after release.
- **Write and read:** write x5=0x1234 via WB, then decode `add x7,x5,x6` with x6=0x10 → ex_read_data1=0x1234, ex_read_data2=0x10, ex_reg_write=1, ex_alu_op=10.
- **Bypass and x0:** WB x3=0xDEAD in the same cycle as decoding `ld x4,-8(x3)` → ex_read_data1=0xDEAD, ex_imm=0xFFFF_FFFF_FFFF_FFF8, ex_mem_read=1. A write to x0 leaves x0 reading 0.
- **Load-use hazard:** `ld x4,0(x3)` followed by `add x5,x4,x1` → hazard_stall=1 for one cycle, then a bubble (ex_valid=0). The add enters ID/EX on the next edge.
- **Branch immediate and flush:** decode `beq x1,x2,-16` → ex_branch=1, ex_imm=-8 (unshifted). Flush asserted with the next instruction → bubble.
- **Stall priority:** stall=1 for 3 cycles → ID/EX unchanged. stall and flush together → bubble.
